mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: FSM states, access-size
// encodings and the size-to-strobe/alignment-mask helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memu_state_e;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;
    localparam logic [1:0] MSIZE_D = 2'd3;

    // Byte-lane strobe for an access of the given size at lane 0.
    function automatic logic [7:0] size_strb(input logic [1:0] size);
        logic [7:0] strb;
        case (size)
            MSIZE_B: strb = 8'h01;
            MSIZE_H: strb = 8'h03;
            MSIZE_W: strb = 8'h0F;
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_lowmask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            MSIZE_B: mask = 3'b000;
            MSIZE_H: mask = 3'b001;
            MSIZE_W: mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus command/response bundle between the memory access unit (master)
// and the memory system (slave).
interface mem_access_unit_if;
    logic        dbus_valid;
    logic        dbus_we;
    logic [63:0] dbus_addr;
    logic [63:0] dbus_wdata;
    logic [7:0]  dbus_strb;
    logic        dbus_ready;
    logic [63:0] dbus_rdata;

    modport master (
        output dbus_valid, dbus_we, dbus_addr, dbus_wdata, dbus_strb,
        input  dbus_ready, dbus_rdata
    );

    modport slave (
        input  dbus_valid, dbus_we, dbus_addr, dbus_wdata, dbus_strb,
        output dbus_ready, dbus_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store data placement and strobes for the request
// being accepted, plus load extraction and sign/zero extension of bus data.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_wdata_i,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_strb_o,
    input  logic [1:0]  ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] shifted;
    logic        sx;

    always_comb begin
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
        st_strb_o  = size_strb(st_size_i) << st_off_i;

        shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
        sx        = 1'b0;
        ld_data_o = shifted;
        case (ld_size_i)
            MSIZE_B: begin
                sx        = ~ld_unsigned_i & shifted[7];
                ld_data_o = {{56{sx}}, shifted[7:0]};
            end
            MSIZE_H: begin
                sx        = ~ld_unsigned_i & shifted[15];
                ld_data_o = {{48{sx}}, shifted[15:0]};
            end
            MSIZE_W: begin
                sx        = ~ld_unsigned_i & shifted[31];
                ld_data_o = {{32{sx}}, shifted[31:0]};
            end
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: IDLE/BUSY/DONE FSM issuing one data-bus transaction per
// accepted op. MEMU_MISALIGN_TRAP_EN enables misaligned-access trapping.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    mem_access_unit_if.master dbus,
    output logic              stallreq_from_memu,
    output logic [63:0]       rdata_o,
    output logic              done_o,
    output logic              misalign_o
);

    memu_state_e state_q, state_d;

    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  strb_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic        uns_q;
    logic [63:0] rdata_q;

    logic        accept;
    logic        capture;
    logic        trap_mis;
    logic [2:0]  req_off;
    logic [63:0] st_wdata;
    logic [7:0]  st_strb;
    logic [63:0] ld_data;

    // Sub-granule address bits are dropped so the lane never straddles the size.
    assign req_off = req_addr[2:0] & ~size_lowmask(req_size);
    assign accept  = (state_q == IDLE) && req_valid;
    assign capture = (state_q == BUSY) && dbus.dbus_ready && !we_q;

`ifdef MEMU_MISALIGN_TRAP_EN
    assign trap_mis = |(req_addr[2:0] & size_lowmask(req_size));
`else
    assign trap_mis = 1'b0;
`endif

    mem_align u_align (
        .st_size_i     (req_size),
        .st_off_i      (req_off),
        .st_wdata_i    (req_wdata),
        .st_wdata_o    (st_wdata),
        .st_strb_o     (st_strb),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (dbus.dbus_rdata),
        .ld_data_o     (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = trap_mis ? DONE : BUSY;
            BUSY:    if (dbus.dbus_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            size_q  <= MSIZE_B;
            off_q   <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept && !trap_mis) begin
                we_q    <= req_we;
                addr_q  <= {req_addr[63:3], 3'b000};
                wdata_q <= st_wdata;
                strb_q  <= st_strb;
                size_q  <= req_size;
                off_q   <= req_off;
                uns_q   <= req_unsigned;
            end
            if (accept && trap_mis) rdata_q <= '0;
            else if (capture)       rdata_q <= ld_data;
        end
    end

`ifdef MEMU_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       misalign_q <= 1'b0;
        else if (accept)               misalign_q <= trap_mis;
        else if (state_q == DONE)      misalign_q <= 1'b0;
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign dbus.dbus_valid = (state_q == BUSY);
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wdata = wdata_q;
    assign dbus.dbus_strb  = strb_q;

    assign stallreq_from_memu = !rst && (accept || (state_q == BUSY));
    assign rdata_o            = rdata_q;
    assign done_o             = (state_q == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, multi-cycle
// corner sequences and randomized ops checked against an arithmetic model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        stall;
    logic [63:0] rdata_o;
    logic        done_o, misalign_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_rdata;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_we             (req_we),
        .req_size           (req_size),
        .req_unsigned       (req_unsigned),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .dbus               (bus),
        .stallreq_from_memu (stall),
        .rdata_o            (rdata_o),
        .done_o             (done_o),
        .misalign_o         (misalign_o)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        logic [63:0] e_addr;
        logic [7:0]  e_strb;
        logic [63:0] e_wlane;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference model: plain byte arithmetic on the access rules.
    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic int m_off(input logic [63:0] a, input logic [1:0] s);
        int n;
        n = nbytes(s);
        return (int'(a[2:0]) / n) * n;
    endfunction

    function automatic logic m_mis(input logic [63:0] a, input logic [1:0] s);
        return (int'(a[2:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] s);
        logic [15:0] t;
        t = ((16'd1 << nbytes(s)) - 16'd1) << m_off(a, s);
        return t[7:0];
    endfunction

    function automatic logic [63:0] m_wlane(input logic [63:0] a, input logic [1:0] s,
                                            input logic [63:0] wd);
        return wd << (8 * m_off(a, s));
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] s,
                                           input logic uns, input logic [63:0] rd);
        logic [63:0] v, mask;
        int n;
        n = nbytes(s);
        v = rd >> (8 * m_off(a, s));
        if (n == 8) return v;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input string nm, input logic we, input logic [1:0] size,
                          input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int waits,
                          input logic [63:0] e_addr, input logic [7:0] e_strb,
                          input logic [63:0] e_wlane, input logic [63:0] e_rdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        bus.dbus_ready = 1'b0; bus.dbus_rdata = {$urandom, $urandom};
        #1;
        chk1({nm, "_acc_stall"}, stall, 1'b1);
        chk1({nm, "_acc_valid"}, bus.dbus_valid, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef MEMU_MISALIGN_TRAP_EN
        if (m_mis(addr, size)) begin
            #1;
            chk1({nm, "_trap_valid"}, bus.dbus_valid, 1'b0);
            chk1({nm, "_trap_done"}, done_o, 1'b1);
            chk1({nm, "_trap_mis"}, misalign_o, 1'b1);
            chk1({nm, "_trap_stall"}, stall, 1'b0);
            chk({nm, "_trap_rdata"}, rdata_o, 64'd0);
            last_rdata = 64'd0;
            @(negedge clk); #1;
            chk1({nm, "_trap_done_end"}, done_o, 1'b0);
            return;
        end
`endif
        for (int w = 0; w <= waits; w++) begin
            bus.dbus_ready = (w == waits);
            bus.dbus_rdata = (w == waits) ? rdata : {$urandom, $urandom};
            #1;
            chk1({nm, "_busy_valid"}, bus.dbus_valid, 1'b1);
            chk1({nm, "_busy_stall"}, stall, 1'b1);
            chk1({nm, "_busy_done"}, done_o, 1'b0);
            chk1({nm, "_we"}, bus.dbus_we, we);
            chk({nm, "_addr"}, bus.dbus_addr, e_addr);
            chk({nm, "_strb"}, 64'(bus.dbus_strb), 64'(e_strb));
            chk({nm, "_wdata"}, bus.dbus_wdata, e_wlane);
            @(negedge clk);
        end
        bus.dbus_ready = 1'b0;
        #1;
        chk1({nm, "_done"}, done_o, 1'b1);
        chk1({nm, "_done_valid"}, bus.dbus_valid, 1'b0);
        chk1({nm, "_done_stall"}, stall, 1'b0);
        chk1({nm, "_done_mis"}, misalign_o, 1'b0);
        chk({nm, "_rdata"}, rdata_o, e_rdata);
        last_rdata = e_rdata;
        @(negedge clk); #1;
        chk1({nm, "_done_end"}, done_o, 1'b0);
        chk({nm, "_rdata_hold"}, rdata_o, e_rdata);
    endtask

    initial begin
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [63:0] r_addr, r_wd, r_rd, r_exp;
        int          txn;

        tbl[0] = '{1'b0, 2'd2, 1'b0, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 0,
                   64'h1000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0001};
        tbl[1] = '{1'b1, 2'd0, 1'b0, 64'h2003, 64'hAB, 64'hDEAD_BEEF_DEAD_BEEF, 3,
                   64'h2000, 8'h08, 64'hAB00_0000, 64'hFFFF_FFFF_8000_0001};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 64'h7, 64'h0, 64'h9C00_0000_0000_0000, 1,
                   64'h0, 8'h80, 64'h0, 64'h9C};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 64'h7, 64'h0, 64'h9C00_0000_0000_0000, 0,
                   64'h0, 8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF9C};
        tbl[4] = '{1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 2,
                   64'h18, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF};
        tbl[5] = '{1'b0, 2'd1, 1'b1, 64'h32, 64'h0, 64'h0000_0000_BEEF_0000, 0,
                   64'h30, 8'h0C, 64'h0, 64'h0000_0000_0000_BEEF};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 64'h32, 64'h0, 64'h0000_0000_BEEF_0000, 1,
                   64'h30, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF};
        tbl[7] = '{1'b1, 2'd2, 1'b0, 64'h44, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF_DEAD_BEEF, 2,
                   64'h40, 8'hF0, 64'h5566_7788_0000_0000, 64'hFFFF_FFFF_FFFF_BEEF};
        tbl[8] = '{1'b0, 2'd2, 1'b1, 64'h40, 64'h0, 64'hFFFF_FFFF_8000_0001, 0,
                   64'h40, 8'h0F, 64'h0, 64'h0000_0000_8000_0001};

        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        bus.dbus_ready = 1'b0; bus.dbus_rdata = 64'd0;
        last_rdata = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_valid", bus.dbus_valid, 1'b0);
        chk1("rst_we", bus.dbus_we, 1'b0);
        chk("rst_addr", bus.dbus_addr, 64'd0);
        chk("rst_wdata", bus.dbus_wdata, 64'd0);
        chk("rst_strb", 64'(bus.dbus_strb), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_mis", misalign_o, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                   tbl[i].wdata, tbl[i].rdata, tbl[i].waits, tbl[i].e_addr, tbl[i].e_strb,
                   tbl[i].e_wlane, tbl[i].e_rdata);

        // Misaligned halfword: traps when enabled, otherwise lands on lane 0.
        run_op("mis_half", 1'b0, 2'd1, 1'b0, 64'h101, 64'h0, 64'h0000_0000_0000_5AA5, 0,
               64'h100, 8'h03, 64'h0, 64'h0000_0000_0000_5AA5);

        // Reset during the second BUSY cycle; a late response must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 64'h20; bus.dbus_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_valid", bus.dbus_valid, 1'b0);
        chk1("midrst_stall", stall, 1'b0);
        chk("midrst_strb", 64'(bus.dbus_strb), 64'd0);
        chk("midrst_addr", bus.dbus_addr, 64'd0);
        chk("midrst_rdata", rdata_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.dbus_ready = 1'b1; bus.dbus_rdata = 64'hCAFE_F00D_CAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1("midrst_late_done", done_o, 1'b0);
            chk1("midrst_late_valid", bus.dbus_valid, 1'b0);
            chk("midrst_late_rdata", rdata_o, 64'd0);
            @(negedge clk);
        end
        bus.dbus_ready = 1'b0;
        last_rdata = 64'd0;

        // Two loads with req_valid held: IDLE, BUSY, DONE twice, then no third op.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h88;
        txn = 0;
        for (int c = 0; c < 7; c++) begin
            int ph;
            ph = c % 3;
            bus.dbus_ready = (ph == 1);
            bus.dbus_rdata = 64'h1111 * 64'(txn + 1);
            #1;
            if (c < 6) begin
                chk1($sformatf("b2b_stall_c%0d", c), stall, ph != 2);
                chk1($sformatf("b2b_valid_c%0d", c), bus.dbus_valid, ph == 1);
                chk1($sformatf("b2b_done_c%0d", c), done_o, ph == 2);
                if (ph == 1) txn++;
                if (ph == 2) chk($sformatf("b2b_rdata_c%0d", c), rdata_o, 64'h1111 * 64'(txn));
                if (c == 5) req_valid = 1'b0;
            end else begin
                chk1("b2b_no_third_valid", bus.dbus_valid, 1'b0);
                chk1("b2b_no_third_stall", stall, 1'b0);
            end
            @(negedge clk);
        end
        #1;
        chk1("b2b_idle_valid", bus.dbus_valid, 1'b0);
        bus.dbus_ready = 1'b0;
        last_rdata = 64'h2222;

        for (int i = 0; i < 40; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = {$urandom, $urandom};
            r_wd   = {$urandom, $urandom};
            r_rd   = {$urandom, $urandom};
            r_exp  = r_we ? last_rdata : m_load(r_addr, r_size, r_uns, r_rd);
            run_op($sformatf("rnd%0d", i), r_we, r_size, r_uns, r_addr, r_wd, r_rd,
                   $urandom_range(0, 3), {r_addr[63:3], 3'b000}, m_strb(r_addr, r_size),
                   m_wlane(r_addr, r_size, r_wd), r_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
